// File: rtl/ysyx_041514_alu_mdu_ctrl_if.sv
// Execute-stage request, mul/div unit handshake and buffered-result bundle for the MDU controller.
// Optional perf counter signals exist only when YSYX_041514_MDU_PERF_EN is defined.
interface ysyx_041514_alu_mdu_ctrl_if #(
  parameter int unsigned XLEN = 64
`ifdef YSYX_041514_MDU_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
);
  logic            req_valid_i;
  logic [1:0]      req_kind_i;
  logic            advance_i;
  logic            flush_i;
  logic            mul_valid_o;
  logic            mul_ready_i;
  logic [XLEN-1:0] mul_data_i;
  logic            div_valid_o;
  logic            div_ready_i;
  logic [XLEN-1:0] div_data_i;
  logic            buff_valid_o;
  logic [XLEN-1:0] buff_data_o;
  logic            stall_req_o;
  logic            busy_o;
`ifdef YSYX_041514_MDU_PERF_EN
  logic [CNT_W-1:0] perf_busy_cyc_o;
  logic [CNT_W-1:0] perf_ops_o;
`endif

  modport master (
    input  req_valid_i, req_kind_i, advance_i, flush_i,
    input  mul_ready_i, mul_data_i, div_ready_i, div_data_i,
    output mul_valid_o, div_valid_o, buff_valid_o, buff_data_o,
    output stall_req_o, busy_o
`ifdef YSYX_041514_MDU_PERF_EN
    , output perf_busy_cyc_o, perf_ops_o
`endif
  );

  modport slave (
    output req_valid_i, req_kind_i, advance_i, flush_i,
    output mul_ready_i, mul_data_i, div_ready_i, div_data_i,
    input  mul_valid_o, div_valid_o, buff_valid_o, buff_data_o,
    input  stall_req_o, busy_o
`ifdef YSYX_041514_MDU_PERF_EN
    , input perf_busy_cyc_o, perf_ops_o
`endif
  );
endinterface

// File: rtl/ysyx_041514_alu_mdu_ctrl.sv
// Mul/div sequencing controller: issues one request, stalls the pipe, buffers the result, drains on flush.
// Define YSYX_041514_MDU_PERF_EN to add busy-cycle and completed-op counters.
module ysyx_041514_alu_mdu_ctrl #(
  parameter int unsigned XLEN = 64
`ifdef YSYX_041514_MDU_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input logic clk,
  input logic rst,
  ysyx_041514_alu_mdu_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state;
  logic            kind_q;        // 1 = div, 0 = mul
  logic            mul_valid_q;
  logic            div_valid_q;
  logic            buff_valid_q;
  logic [XLEN-1:0] buff_q;
  logic            req_ok;
  logic            req_div;
  logic            sel_ready;

  assign req_ok    = bus.req_valid_i & ~bus.flush_i & (bus.req_kind_i != 2'b00);
  assign req_div   = (bus.req_kind_i == 2'b10);
  // Only the unit that was issued to can complete the operation.
  assign sel_ready = kind_q ? bus.div_ready_i : bus.mul_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      kind_q       <= 1'b0;
      mul_valid_q  <= 1'b0;
      div_valid_q  <= 1'b0;
      buff_valid_q <= 1'b0;
      buff_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ok) begin
            state       <= BUSY;
            kind_q      <= req_div;
            mul_valid_q <= ~req_div;
            div_valid_q <= req_div;
          end
        end
        BUSY: begin
          if (sel_ready) begin
            mul_valid_q <= 1'b0;
            div_valid_q <= 1'b0;
            if (bus.flush_i) begin
              state <= IDLE;
            end else begin
              state        <= DONE;
              buff_valid_q <= 1'b1;
              buff_q       <= kind_q ? bus.div_data_i : bus.mul_data_i;
            end
          end else if (bus.flush_i) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          if (bus.advance_i | bus.flush_i) begin
            state        <= IDLE;
            buff_valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (sel_ready) begin
            state       <= IDLE;
            mul_valid_q <= 1'b0;
            div_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mul_valid_o  = mul_valid_q;
  assign bus.div_valid_o  = div_valid_q;
  assign bus.buff_valid_o = buff_valid_q;
  assign bus.buff_data_o  = buff_q;
  assign bus.busy_o       = (state != IDLE);
  assign bus.stall_req_o  = (state == BUSY) | (((state == IDLE) | (state == DRAIN)) & req_ok);

`ifdef YSYX_041514_MDU_PERF_EN
  logic [CNT_W-1:0] busy_cyc_q;
  logic [CNT_W-1:0] ops_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cyc_q <= '0;
      ops_q      <= '0;
    end else begin
      if ((state == BUSY) | (state == DRAIN)) busy_cyc_q <= busy_cyc_q + 1'b1;
      if ((state == BUSY) & sel_ready & ~bus.flush_i) ops_q <= ops_q + 1'b1;
    end
  end

  assign bus.perf_busy_cyc_o = busy_cyc_q;
  assign bus.perf_ops_o      = ops_q;
`endif

endmodule

// File: tb/tb_ysyx_041514_alu_mdu_ctrl.sv
// Scoreboard bench for ysyx_041514_alu_mdu_ctrl: directed mul/div/flush/reset scenarios.
module tb_ysyx_041514_alu_mdu_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] exp_q[$];
  logic prev_bv = 1'b0;

  always #5 clk = ~clk;

`ifdef YSYX_041514_MDU_PERF_EN
  ysyx_041514_alu_mdu_ctrl_if #(.XLEN(64), .CNT_W(32)) bus ();
  ysyx_041514_alu_mdu_ctrl #(.XLEN(64), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  ysyx_041514_alu_mdu_ctrl_if #(.XLEN(64)) bus ();
  ysyx_041514_alu_mdu_ctrl #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req_valid_i = 1'b0;
    bus.req_kind_i  = 2'b00;
    bus.advance_i   = 1'b0;
    bus.flush_i     = 1'b0;
    bus.mul_ready_i = 1'b0;
    bus.mul_data_i  = '0;
    bus.div_ready_i = 1'b0;
    bus.div_data_i  = '0;
  endtask

  // Monitor: every new buffered result is compared with the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.buff_valid_o && !prev_bv) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL buff_unexpected: got %h expected no result", bus.buff_data_o);
        end else begin
          chk("buff_data", bus.buff_data_o, exp_q.pop_front());
        end
      end
      prev_bv = bus.buff_valid_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    rst = 1'b1;
    fin();
    fin();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_buff_valid", bus.buff_valid_o, 0);
    chk("rst_buff_data", bus.buff_data_o, 0);
    chk("rst_mul_valid", bus.mul_valid_o, 0);
    chk("rst_div_valid", bus.div_valid_o, 0);
    chk("rst_stall", bus.stall_req_o, 0);
    fin();

    // Mul latency; a stray div ready mid-op must be ignored.
    bus.req_valid_i = 1'b1; bus.req_kind_i = 2'b01;
    @(negedge clk);
    chk("t1_c0_stall", bus.stall_req_o, 1);
    chk("t1_c0_mul_valid", bus.mul_valid_o, 0);
    fin();
    for (int c = 1; c <= 4; c++) begin
      bus.div_ready_i = (c == 3);
      bus.div_data_i  = 64'hBAD;
      @(negedge clk);
      chk("t1_stall", bus.stall_req_o, 1);
      chk("t1_mul_valid", bus.mul_valid_o, 1);
      chk("t1_div_valid", bus.div_valid_o, 0);
      fin();
    end
    bus.div_ready_i = 1'b0;
    chk("t1_c5_busy", bus.busy_o, 1);
    chk("t1_c5_bv", bus.buff_valid_o, 0);
    bus.mul_ready_i = 1'b1; bus.mul_data_i = 64'h1234;
    exp_q.push_back(64'h1234);
    @(negedge clk);
    chk("t1_c5_stall", bus.stall_req_o, 1);
    fin();
    bus.mul_ready_i = 1'b0;
    for (int c = 6; c <= 7; c++) begin
      @(negedge clk);
      chk("t1_bv", bus.buff_valid_o, 1);
      chk("t1_bdata", bus.buff_data_o, 64'h1234);
      chk("t1_done_stall", bus.stall_req_o, 0);
      chk("t1_done_mul_valid", bus.mul_valid_o, 0);
      fin();
    end
    bus.advance_i = 1'b1;
    @(negedge clk);
    chk("t1_c8_bv", bus.buff_valid_o, 1);
    fin();
    bus.advance_i = 1'b0; bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("t1_c9_bv", bus.buff_valid_o, 0);
    chk("t1_c9_busy", bus.busy_o, 0);
    fin();

    // Kind 00 is never accepted.
    bus.req_valid_i = 1'b1; bus.req_kind_i = 2'b00;
    @(negedge clk);
    chk("k00_stall", bus.stall_req_o, 0);
    fin();
    @(negedge clk);
    chk("k00_busy", bus.busy_o, 0);
    fin();

    // Kind 11 behaves as mul.
    bus.req_kind_i = 2'b11;
    fin();
    bus.mul_ready_i = 1'b1; bus.mul_data_i = 64'h11;
    exp_q.push_back(64'h11);
    @(negedge clk);
    chk("k11_mul_valid", bus.mul_valid_o, 1);
    chk("k11_div_valid", bus.div_valid_o, 0);
    fin();
    bus.mul_ready_i = 1'b0; bus.advance_i = 1'b1;
    @(negedge clk);
    chk("k11_bv", bus.buff_valid_o, 1);
    fin();
    bus.advance_i = 1'b0; bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("k11_idle", bus.busy_o, 0);
    fin();

    // Div result held while advance stays low; no re-issue.
    bus.req_valid_i = 1'b1; bus.req_kind_i = 2'b10;
    fin();
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      chk("t2_div_valid", bus.div_valid_o, 1);
      fin();
    end
    bus.div_ready_i = 1'b1; bus.div_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    fin();
    bus.div_ready_i = 1'b0; bus.div_data_i = '0;
    for (int c = 35; c <= 44; c++) begin
      @(negedge clk);
      chk("t2_bv", bus.buff_valid_o, 1);
      chk("t2_bdata", bus.buff_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t2_div_valid", bus.div_valid_o, 0);
      chk("t2_stall", bus.stall_req_o, 0);
      fin();
    end
    bus.advance_i = 1'b1;
    fin();
    bus.advance_i = 1'b0; bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("t2_bv_clear", bus.buff_valid_o, 0);
    fin();

    // Flush mid-div, drain, then a new mul is accepted after IDLE.
    bus.req_valid_i = 1'b1; bus.req_kind_i = 2'b10;
    fin();
    fin();
    fin();
    bus.flush_i = 1'b1; bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("t3_c3_stall", bus.stall_req_o, 1);
    fin();
    bus.flush_i = 1'b0; bus.req_valid_i = 1'b1; bus.req_kind_i = 2'b01;
    for (int c = 4; c <= 19; c++) begin
      @(negedge clk);
      chk("t3_drain_stall", bus.stall_req_o, 1);
      chk("t3_drain_div_valid", bus.div_valid_o, 1);
      chk("t3_drain_mul_valid", bus.mul_valid_o, 0);
      fin();
    end
    bus.div_ready_i = 1'b1; bus.div_data_i = 64'hDEAD;
    @(negedge clk);
    chk("t3_c20_div_valid", bus.div_valid_o, 1);
    chk("t3_c20_stall", bus.stall_req_o, 1);
    fin();
    bus.div_ready_i = 1'b0;
    @(negedge clk);
    chk("t3_c21_mul_valid", bus.mul_valid_o, 0);
    chk("t3_c21_div_valid", bus.div_valid_o, 0);
    chk("t3_c21_bv", bus.buff_valid_o, 0);
    chk("t3_c21_stall", bus.stall_req_o, 1);
    fin();
    bus.mul_ready_i = 1'b1; bus.mul_data_i = 64'h55;
    exp_q.push_back(64'h55);
    @(negedge clk);
    chk("t3_c22_mul_valid", bus.mul_valid_o, 1);
    fin();
    bus.mul_ready_i = 1'b0; bus.advance_i = 1'b1;
    @(negedge clk);
    chk("t3_bdata", bus.buff_data_o, 64'h55);
    fin();
    bus.advance_i = 1'b0; bus.req_valid_i = 1'b0;
    fin();

    // Flush coincident with the selected ready: straight to IDLE, result dropped.
    bus.req_valid_i = 1'b1; bus.req_kind_i = 2'b01;
    fin();
    fin();
    bus.flush_i = 1'b1; bus.mul_ready_i = 1'b1; bus.mul_data_i = 64'h77; bus.req_valid_i = 1'b0;
    fin();
    bus.flush_i = 1'b0; bus.mul_ready_i = 1'b0;
    @(negedge clk);
    chk("t4_busy", bus.busy_o, 0);
    chk("t4_bv", bus.buff_valid_o, 0);
    chk("t4_mul_valid", bus.mul_valid_o, 0);
    chk("t4_stall", bus.stall_req_o, 0);
    chk("t4_bdata", bus.buff_data_o, 64'h55);
    fin();

    // Asynchronous reset between clock edges while BUSY.
    bus.req_valid_i = 1'b1; bus.req_kind_i = 2'b01;
    fin();
    fin();
    fin();
    @(negedge clk);
    chk("t5_pre_mul_valid", bus.mul_valid_o, 1);
    chk("t5_pre_busy", bus.busy_o, 1);
    #2;
    rst = 1'b1; bus.req_valid_i = 1'b0;
    #1;
    chk("t5_mul_valid", bus.mul_valid_o, 0);
    chk("t5_stall", bus.stall_req_o, 0);
    chk("t5_busy", bus.busy_o, 0);
    chk("t5_bdata", bus.buff_data_o, 0);
    fin();
    rst = 1'b0;
    fin();

`ifdef YSYX_041514_MDU_PERF_EN
    // Two mul ops, four busy cycles each.
    for (int k = 0; k < 2; k++) begin
      bus.req_valid_i = 1'b1; bus.req_kind_i = 2'b01;
      fin();
      fin();
      fin();
      fin();
      bus.mul_ready_i = 1'b1; bus.mul_data_i = 64'(k + 1);
      exp_q.push_back(64'(k + 1));
      fin();
      bus.mul_ready_i = 1'b0; bus.advance_i = 1'b1;
      fin();
      bus.advance_i = 1'b0; bus.req_valid_i = 1'b0;
      fin();
    end
    @(negedge clk);
    chk("perf_ops", 64'(bus.perf_ops_o), 2);
    chk("perf_busy_cyc", 64'(bus.perf_busy_cyc_o), 8);
    fin();
`endif

    chk("pending_results", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_041514_alu_mdu_ctrl.md
Name: ysyx_041514_alu_mdu_ctrl

Overview:
- Sequencing controller for the ALU's multi-cycle multiply and divide units. Sits beside the ALU in the execute stage.
- Accepts one mul/div request from the execute instruction and drives the unit's valid/ready handshake.
- Raises the pipeline stall request while the unit is busy, then captures the result into a buffer. The ALU selects that buffer via its buffered-result inputs until the pipeline advances.
- Handles flush while a unit is busy by draining it and discarding the result.

Parameters:
- XLEN, 64, datapath width
- CNT_W, 32, width of optional performance counters

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req_valid_i  input  1  execute instruction is mul/div class (level, held while instruction sits in EX)
- req_kind_i  input  2  bit0=mul, bit1=div; 2'b11 treated as mul; 2'b00 never accepted
- advance_i  input  1  EX instruction leaves stage this cycle
- flush_i  input  1  kill EX instruction
- mul_valid_o  output  1  request to multiplier, held until mul_ready_i
- mul_ready_i  input  1  multiplier result valid (one cycle)
- mul_data_i  input  XLEN  multiplier result (already op-selected)
- div_valid_o  output  1  request to divider, held until div_ready_i
- div_ready_i  input  1  divider result valid (one cycle)
- div_data_i  input  XLEN  divider result
- buff_valid_o  output  1  buffered result valid; drives ALU buffered-valid input
- buff_data_o  output  XLEN  buffered result
- stall_req_o  output  1  stall pipeline
- busy_o  output  1  state != IDLE

Behaviour:
- States: IDLE, BUSY, DONE, DRAIN. Registered kind_q (mul/div).
- Reset (async, any state, mid-operation included): state=IDLE, kind_q=mul, buff_valid_o=0, buff_data_o=0, all *_valid_o=0. Perf counters cleared.
- IDLE: req_valid_i & ~flush_i & kind!=00 -> BUSY, latch kind_q. Otherwise stay.
- BUSY:
  - mul_valid_o = kind_q==mul; div_valid_o = kind_q==div. Outputs are registered-state decoded, so the first valid appears the cycle after acceptance.
  - The selected unit's ready -> capture data into buff_data_o, go DONE.
  - The other unit's ready is ignored.
- DONE: buff_valid_o=1; buff_data_o stable. advance_i or flush_i -> IDLE and clear buff_valid_o. req_valid_i stays high in DONE and must not re-issue.
- DRAIN:
  - Keeps the selected unit's valid high until its ready, then -> IDLE. Result is discarded; buffer untouched (invalid).
  - A new request arriving during DRAIN is stalled and accepted only after returning to IDLE.
- BUSY + flush_i:
  - If the selected unit's ready is asserted the same cycle -> IDLE, result discarded.
  - Else -> DRAIN.
- stall_req_o = BUSY | ((IDLE|DRAIN) & req_valid_i & ~flush_i & kind!=00). Combinational, so it asserts in the acceptance cycle. It is 0 in DONE.
- Latency: request at cycle 0; valid_o from cycle 1; unit ready at cycle N gives buff_valid_o=1 at N+1 and stall_req_o=0 at N+1.
- Simultaneous advance_i and flush_i in DONE: -> IDLE (same as either).
- Single outstanding operation; no queueing.

Optional Feature:
- Macro: YSYX_041514_MDU_PERF_EN.
- Defined:
  - Adds outputs perf_busy_cyc_o [CNT_W-1:0] and perf_ops_o [CNT_W-1:0].
  - perf_busy_cyc_o increments every cycle in BUSY or DRAIN.
  - perf_ops_o increments on each BUSY->DONE.
  - Both wrap at 2^CNT_W and are cleared by rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Mul latency check:
  - Stimulus: req kind=01 at cycle 0; mul_ready_i=1 with mul_data_i=64'h1234 at cycle 5.
  - Response: stall_req_o=1 cycles 0-5; mul_valid_o=1 cycles 1-5; buff_valid_o=1, buff_data_o=64'h1234 from cycle 6; advance_i at cycle 8 -> buff_valid_o=0 at cycle 9, IDLE.
- Div held result:
  - Stimulus: req kind=10; div_ready_i at cycle 34, data 64'hFFFF_FFFF_FFFF_FFFF; advance_i held low 10 cycles.
  - Response: buff_valid_o stays high with that data; no second div_valid_o while req_valid_i stays high.
- Flush mid-op:
  - Stimulus: div accepted; flush_i at cycle 3; new mul req at cycle 4; div_ready_i at cycle 20.
  - Response: DRAIN with div_valid_o high to cycle 20; stall_req_o=1 cycles 4-20; mul_valid_o first at cycle 22; div data never reaches buff_data_o.
- Flush coincident with ready:
  - Stimulus: mul in BUSY; flush_i and mul_ready_i same cycle.
  - Response: next state IDLE, buff_valid_o=0.
- Async reset mid-BUSY:
  - Stimulus: assert rst between clock edges at cycle 3 of a mul.
  - Response: mul_valid_o, stall_req_o, busy_o drop to 0 immediately; buffer 0.
- Perf (YSYX_041514_MDU_PERF_EN defined):
  - Stimulus: two mul ops with 4-cycle unit latency.
  - Response: perf_ops_o=2, perf_busy_cyc_o=8.
